cart_mem_arbiter: RTL and testbench

- Shares one external cartridge memory port between two requesters: CPU PRG ROM/RAM accesses and PPU CHR accesses.
- The mapper's extended addresses feed this block: PRG ROM 19b, PRG RAM 15b, CHR 18b.
- Translates each request into a flat 20-bit memory address and sequences it through a req/gnt/rvalid handshake, one transaction outstanding.
- PPU has fixed priority; a streak counter bounds CPU starvation.

---
 rtl/nes_cart_mem_pkg.sv | 29 ++
 rtl/cart_mem_addr_map.sv | 37 +++
 rtl/cart_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_cart_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_cart_mem_pkg.sv
// Shared types and constants for the cartridge memory arbiter: region prefixes,
// FSM state encoding and transaction owner encoding.
package nes_cart_mem_pkg;

  localparam int unsigned FLAT_ADDR_W = 20;

  localparam logic [FLAT_ADDR_W-1:0] PRG_ROM_BASE = 20'h00000;
  localparam logic [FLAT_ADDR_W-1:0] CHR_BASE     = 20'h80000;
  localparam logic [FLAT_ADDR_W-1:0] PRG_RAM_BASE = 20'hC0000;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRd,
    StDone
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_PPU = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    RegPrgRom,
    RegPrgRam,
    RegChr
  } region_e;

endpackage

// File: rtl/cart_mem_addr_map.sv
// Translates a mapper-level address into the flat cartridge memory address and
// decides whether the access must be dropped without a memory cycle.
module cart_mem_addr_map
  import nes_cart_mem_pkg::*;
(
  input  region_e                  region_i,
  input  logic                     we_i,
  input  logic [18:0]              rom_addr_i,
  input  logic [14:0]              ram_addr_i,
  input  logic [17:0]              chr_addr_i,
  input  logic                     chr_is_ram_i,
  input  logic                     prg_ram_en_i,
  output logic [FLAT_ADDR_W-1:0]   addr_o,
  output logic                     drop_o
);

  always_comb begin
    addr_o = PRG_ROM_BASE | FLAT_ADDR_W'(rom_addr_i);
    drop_o = we_i;
    case (region_i)
      RegPrgRam: begin
        addr_o = PRG_RAM_BASE | FLAT_ADDR_W'(ram_addr_i);
        drop_o = ~prg_ram_en_i;
      end
      RegChr: begin
        addr_o = CHR_BASE | FLAT_ADDR_W'(chr_addr_i);
        drop_o = we_i & ~chr_is_ram_i;
      end
      default: begin
        // PRG ROM is read-only: writes are swallowed.
        addr_o = PRG_ROM_BASE | FLAT_ADDR_W'(rom_addr_i);
        drop_o = we_i;
      end
    endcase
  end

endmodule

// File: rtl/cart_mem_arbiter.sv
// Shares one cartridge memory port between CPU PRG and PPU CHR requesters with
// PPU priority, a bounded PPU streak, and one req/gnt/rvalid transaction in flight.
module cart_mem_arbiter
  import nes_cart_mem_pkg::*;
#(
  parameter int unsigned MEM_ADDR_W     = 20,
  parameter int unsigned PPU_STREAK_MAX = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_sel_ram_i,
  input  logic                  cpu_we_i,
  input  logic [18:0]           cpu_rom_addr_i,
  input  logic [14:0]           cpu_ram_addr_i,
  input  logic [7:0]            cpu_wdata_i,
  output logic                  cpu_ack_o,
  output logic [7:0]            cpu_rdata_o,
  input  logic                  ppu_req_i,
  input  logic                  ppu_we_i,
  input  logic [17:0]           ppu_addr_i,
  input  logic [7:0]            ppu_wdata_i,
  output logic                  ppu_ack_o,
  output logic [7:0]            ppu_rdata_o,
  input  logic                  chr_is_ram_i,
  input  logic                  prg_ram_en_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [7:0]            mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [7:0]            mem_rdata_i
);

  state_e                  r_state, w_state_nxt;
  owner_e                  r_owner;
  logic                    r_we;
  logic [MEM_ADDR_W-1:0]   r_addr;
  logic [7:0]              r_wdata, r_cpu_rdata, r_ppu_rdata;
  logic [3:0]              r_streak;

  region_e                 w_cpu_region;
  logic [FLAT_ADDR_W-1:0]  w_cpu_addr, w_ppu_addr, w_win_addr;
  logic                    w_cpu_drop, w_ppu_drop, w_win_drop;
  logic                    w_idle, w_streak_full, w_win_ppu, w_win_cpu, w_win_we;
  logic [7:0]              w_win_wdata;

  assign w_cpu_region = cpu_sel_ram_i ? RegPrgRam : RegPrgRom;

  cart_mem_addr_map u_cpu_map (
    .region_i     (w_cpu_region),
    .we_i         (cpu_we_i),
    .rom_addr_i   (cpu_rom_addr_i),
    .ram_addr_i   (cpu_ram_addr_i),
    .chr_addr_i   (18'h0),
    .chr_is_ram_i (chr_is_ram_i),
    .prg_ram_en_i (prg_ram_en_i),
    .addr_o       (w_cpu_addr),
    .drop_o       (w_cpu_drop)
  );

  cart_mem_addr_map u_ppu_map (
    .region_i     (RegChr),
    .we_i         (ppu_we_i),
    .rom_addr_i   (19'h0),
    .ram_addr_i   (15'h0),
    .chr_addr_i   (ppu_addr_i),
    .chr_is_ram_i (chr_is_ram_i),
    .prg_ram_en_i (prg_ram_en_i),
    .addr_o       (w_ppu_addr),
    .drop_o       (w_ppu_drop)
  );

  // PPU wins ties unless it has already starved a waiting CPU for the full streak.
  assign w_idle        = (r_state == StIdle);
  assign w_streak_full = (r_streak == 4'(PPU_STREAK_MAX));
  assign w_win_ppu     = w_idle & ppu_req_i & (~cpu_req_i | ~w_streak_full);
  assign w_win_cpu     = w_idle & cpu_req_i & ~w_win_ppu;
  assign w_win_drop    = w_win_ppu ? w_ppu_drop  : w_cpu_drop;
  assign w_win_we      = w_win_ppu ? ppu_we_i    : cpu_we_i;
  assign w_win_addr    = w_win_ppu ? w_ppu_addr  : w_cpu_addr;
  assign w_win_wdata   = w_win_ppu ? ppu_wdata_i : cpu_wdata_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_win_ppu || w_win_cpu) begin
          w_state_nxt = w_win_drop ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (mem_gnt_i) begin
          w_state_nxt = r_we ? StDone : StWaitRd;
        end
      end
      StWaitRd: begin
        if (mem_rvalid_i) begin
          w_state_nxt = StDone;
        end
      end
      StDone:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_owner     <= OWN_CPU;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 8'h00;
      r_cpu_rdata <= 8'h00;
      r_ppu_rdata <= 8'h00;
      r_streak    <= 4'd0;
    end else begin
      if (w_win_ppu || w_win_cpu) begin
        r_owner <= w_win_ppu ? OWN_PPU : OWN_CPU;
        r_we    <= w_win_we;
        r_addr  <= MEM_ADDR_W'(w_win_addr);
        r_wdata <= w_win_wdata;
        // A dropped read completes with 0x00 as its data.
        if (w_win_drop && !w_win_we) begin
          if (w_win_ppu) r_ppu_rdata <= 8'h00;
          else           r_cpu_rdata <= 8'h00;
        end
      end
      if (r_state == StWaitRd && mem_rvalid_i) begin
        if (r_owner == OWN_PPU) r_ppu_rdata <= mem_rdata_i;
        else                    r_cpu_rdata <= mem_rdata_i;
      end
      if (w_win_cpu) begin
        r_streak <= 4'd0;
      end else if (w_win_ppu && cpu_req_i) begin
        if (!w_streak_full) r_streak <= r_streak + 4'd1;
      end else if (w_idle && !cpu_req_i) begin
        r_streak <= 4'd0;
      end
    end
  end

  assign mem_req_o   = (r_state == StIssue);
  assign mem_we_o    = mem_req_o & r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign cpu_ack_o   = (r_state == StDone) && (r_owner == OWN_CPU);
  assign ppu_ack_o   = (r_state == StDone) && (r_owner == OWN_PPU);
  assign cpu_rdata_o = r_cpu_rdata;
  assign ppu_rdata_o = r_ppu_rdata;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed bench for cart_mem_arbiter: a vector table of single transactions plus
// hand sequences for spurious rvalid, contention and reset mid-transaction.
module tb_cart_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        cpu_req_i = 1'b0, cpu_sel_ram_i = 1'b0, cpu_we_i = 1'b0;
  logic [18:0] cpu_rom_addr_i = '0;
  logic [14:0] cpu_ram_addr_i = '0;
  logic [7:0]  cpu_wdata_i = '0;
  logic        cpu_ack_o;
  logic [7:0]  cpu_rdata_o;
  logic        ppu_req_i = 1'b0, ppu_we_i = 1'b0;
  logic [17:0] ppu_addr_i = '0;
  logic [7:0]  ppu_wdata_i = '0;
  logic        ppu_ack_o;
  logic [7:0]  ppu_rdata_o;
  logic        chr_is_ram_i = 1'b0, prg_ram_en_i = 1'b0;
  logic        mem_req_o, mem_we_o;
  logic [19:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [7:0]  mem_rdata_i = '0;

  always #5 clk_i = ~clk_i;

  cart_mem_arbiter #(
    .MEM_ADDR_W     (20),
    .PPU_STREAK_MAX (4)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .cpu_req_i      (cpu_req_i),
    .cpu_sel_ram_i  (cpu_sel_ram_i),
    .cpu_we_i       (cpu_we_i),
    .cpu_rom_addr_i (cpu_rom_addr_i),
    .cpu_ram_addr_i (cpu_ram_addr_i),
    .cpu_wdata_i    (cpu_wdata_i),
    .cpu_ack_o      (cpu_ack_o),
    .cpu_rdata_o    (cpu_rdata_o),
    .ppu_req_i      (ppu_req_i),
    .ppu_we_i       (ppu_we_i),
    .ppu_addr_i     (ppu_addr_i),
    .ppu_wdata_i    (ppu_wdata_i),
    .ppu_ack_o      (ppu_ack_o),
    .ppu_rdata_o    (ppu_rdata_o),
    .chr_is_ram_i   (chr_is_ram_i),
    .prg_ram_en_i   (prg_ram_en_i),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_ppu;
    logic        sel_ram;
    logic        we;
    logic [18:0] rom;
    logic [14:0] ram;
    logic [17:0] chr;
    logic [7:0]  wdata;
    logic        chr_ram;
    logic        ram_en;
    int          gnt_dly;
    logic [7:0]  mem_rd;
    logic [19:0] exp_addr;
    int          exp_issue;   // cycles mem_req_o is high
    int          exp_lat;     // edges from req sampled to ack visible
    logic        chk_rd;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v, input int idx);
    int  issue;
    int  lat;
    logic pend, rv, gnt, own_ack;
    @(posedge clk_i);
    #1;
    cpu_req_i      = ~v.is_ppu;
    ppu_req_i      = v.is_ppu;
    cpu_sel_ram_i  = v.sel_ram;
    cpu_we_i       = v.is_ppu ? 1'b0 : v.we;
    ppu_we_i       = v.is_ppu ? v.we : 1'b0;
    cpu_rom_addr_i = v.rom;
    cpu_ram_addr_i = v.ram;
    ppu_addr_i     = v.chr;
    cpu_wdata_i    = v.wdata;
    ppu_wdata_i    = v.wdata;
    chr_is_ram_i   = v.chr_ram;
    prg_ram_en_i   = v.ram_en;
    mem_rdata_i    = v.mem_rd;
    issue = 0;
    lat   = -1;
    pend  = 1'b0;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge clk_i);
      if (mem_req_o) begin
        chk($sformatf("v%0d_addr", idx), mem_addr_o, v.exp_addr);
        chk($sformatf("v%0d_we", idx), mem_we_o, v.we);
        if (v.we) chk($sformatf("v%0d_wdata", idx), mem_wdata_o, v.wdata);
      end
      chk($sformatf("v%0d_dual_ack", idx), cpu_ack_o & ppu_ack_o, 0);
      own_ack = v.is_ppu ? ppu_ack_o : cpu_ack_o;
      if (own_ack) begin
        lat = c;
        if (v.chk_rd) begin
          chk($sformatf("v%0d_rdata", idx), v.is_ppu ? ppu_rdata_o : cpu_rdata_o, v.exp_rd);
        end
        cpu_req_i = 1'b0;
        ppu_req_i = 1'b0;
      end
      rv   = pend;
      pend = 1'b0;
      gnt  = mem_req_o && (issue >= v.gnt_dly);
      if (mem_req_o) issue++;
      if (gnt && !mem_we_o) pend = 1'b1;
      mem_gnt_i    = gnt;
      mem_rvalid_i = rv;
    end
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_issue_cycles", idx), issue, v.exp_issue);
    cpu_req_i    = 1'b0;
    ppu_req_i    = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    logic got[10];
    int   n;

    //          ppu   ram   we    rom        ram        chr        wdata  chr   en   dly rd     exp_addr    iss lat chk   exp_rd
    vecs[0] = '{1'b0, 1'b0, 1'b0, 19'h12345, 15'h0000, 18'h00000, 8'h00, 1'b1, 1'b1, 0, 8'hA5, 20'h12345, 1, 3, 1'b1, 8'hA5};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 19'h00000, 15'h0000, 18'h01F00, 8'h3C, 1'b1, 1'b1, 2, 8'h00, 20'h81F00, 3, 4, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 19'h00100, 15'h0000, 18'h00000, 8'h99, 1'b1, 1'b1, 0, 8'h00, 20'h00000, 0, 1, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 19'h00000, 15'h0040, 18'h00000, 8'h00, 1'b1, 1'b0, 0, 8'hEE, 20'h00000, 0, 1, 1'b1, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 19'h00000, 15'h0000, 18'h00200, 8'h42, 1'b0, 1'b1, 0, 8'h00, 20'h00000, 0, 1, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 19'h00000, 15'h7FFF, 18'h00000, 8'h00, 1'b1, 1'b1, 0, 8'h5A, 20'hC7FFF, 1, 3, 1'b1, 8'h5A};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 19'h00000, 15'h0000, 18'h3FFFF, 8'h00, 1'b1, 1'b1, 1, 8'hC3, 20'hBFFFF, 2, 4, 1'b1, 8'hC3};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 19'h00000, 15'h0010, 18'h00000, 8'h77, 1'b1, 1'b1, 0, 8'h00, 20'hC0010, 1, 2, 1'b0, 8'h00};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 19'h7FFFF, 15'h0000, 18'h00000, 8'h00, 1'b1, 1'b1, 0, 8'h11, 20'h7FFFF, 1, 3, 1'b1, 8'h11};

    // Power-on reset
    #2 rst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("reset_mem_req", mem_req_o, 0);
    chk("reset_mem_we", mem_we_o, 0);
    chk("reset_mem_addr", mem_addr_o, 0);
    chk("reset_mem_wdata", mem_wdata_o, 0);
    chk("reset_acks", {cpu_ack_o, ppu_ack_o}, 0);
    chk("reset_rdata", {cpu_rdata_o, ppu_rdata_o}, 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Spurious rvalid while idle must not disturb either rdata register
    @(posedge clk_i);
    #1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 8'hFF;
    repeat (2) @(negedge clk_i);
    chk("spur_cpu_rdata", cpu_rdata_o, 8'h11);
    chk("spur_ppu_rdata", ppu_rdata_o, 8'hC3);
    chk("spur_acks", {cpu_ack_o, ppu_ack_o}, 0);
    chk("spur_mem_req", mem_req_o, 0);
    mem_rvalid_i = 1'b0;

    // Contention: both writers request continuously
    @(posedge clk_i);
    #1;
    cpu_sel_ram_i  = 1'b1;
    cpu_we_i       = 1'b1;
    cpu_ram_addr_i = 15'h0001;
    cpu_wdata_i    = 8'h55;
    prg_ram_en_i   = 1'b1;
    ppu_we_i       = 1'b1;
    ppu_addr_i     = 18'h00002;
    ppu_wdata_i    = 8'hAA;
    chr_is_ram_i   = 1'b1;
    cpu_req_i      = 1'b1;
    ppu_req_i      = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      @(negedge clk_i);
      chk("cont_dual_ack", cpu_ack_o & ppu_ack_o, 0);
      if (cpu_ack_o) begin
        got[n] = 1'b0;
        n++;
      end else if (ppu_ack_o) begin
        got[n] = 1'b1;
        n++;
      end
      mem_gnt_i = mem_req_o;
    end
    chk("cont_ack_count", n, 10);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("cont_owner%0d", i), got[i], (i % 5 == 4) ? 0 : 1);
    end
    cpu_req_i = 1'b0;
    ppu_req_i = 1'b0;
    mem_gnt_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // Reset asserted while a CPU read sits in ISSUE without a grant
    @(posedge clk_i);
    #1;
    cpu_sel_ram_i  = 1'b0;
    cpu_we_i       = 1'b0;
    cpu_rom_addr_i = 19'h00ABC;
    cpu_req_i      = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_pre_req", mem_req_o, 1);
    rst_n_i = 1'b0;
    #1;
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_cpu_ack", cpu_ack_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_cpu_rdata", cpu_rdata_o, 0);
    cpu_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("post_rst_acks", {cpu_ack_o, ppu_ack_o}, 0);
      chk("post_rst_mem_req", mem_req_o, 0);
    end
    chk("post_rst_mem_addr", mem_addr_o, 0);
    chk("post_rst_mem_wdata", mem_wdata_o, 0);
    chk("post_rst_mem_we", mem_we_o, 0);
    chk("post_rst_ppu_rdata", ppu_rdata_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
